// File: rtl/quad_input_filter.sv
// Per-channel metastability synchroniser and stable-count debouncer with registered edge strobes.
// Optional: define QUAD_GLITCH_COUNT_EN for a saturating count of aborted transitions on glitch_cnt.
`timescale 1ns/1ps
module quad_input_filter #(
   parameter int CHANNELS        = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] raw_in,
   output logic [CHANNELS-1:0] clean_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic [7:0]          glitch_cnt
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} chan_state_t;

   logic [CHANNELS-1:0] sync_ff [SYNC_STAGES];
   logic [CHANNELS-1:0] sync;
   logic [CW-1:0]       cnt_q [CHANNELS];
   logic [CW-1:0]       cnt_d [CHANNELS];
   logic [CHANNELS-1:0] clean_q;
   logic [CHANNELS-1:0] rise_q;
   logic [CHANNELS-1:0] fall_q;
   logic [CHANNELS-1:0] flip_d;
   chan_state_t         chan_state [CHANNELS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_ff[s] <= '0;
      end else begin
         sync_ff[0] <= raw_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
      end
   end

   assign sync = sync_ff[SYNC_STAGES-1];

   // A channel is PENDING while its counter holds progress towards a flip.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         chan_state[i] = (cnt_q[i] != '0) ? ST_PENDING : ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
         clean_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
         clean_q <= clean_q ^ flip_d;
         rise_q  <= flip_d & sync;
         fall_q  <= flip_d & ~sync;
      end
   end

   always_comb begin
      flip_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = '0;
         case (chan_state[i])
            ST_IDLE: begin
               if (sync[i] != clean_q[i]) begin
                  if (CNT_MAX == '0) flip_d[i] = 1'b1;
                  else               cnt_d[i]  = CW'(1);
               end
            end
            ST_PENDING: begin
               // Returning to the clean level abandons the transition.
               if (sync[i] != clean_q[i]) begin
                  if (cnt_q[i] == CNT_MAX) flip_d[i] = 1'b1;
                  else                     cnt_d[i]  = cnt_q[i] + CW'(1);
               end
            end
            default: cnt_d[i] = '0;
         endcase
      end
   end

   always_comb begin
      clean_out  = clean_q;
      rise_pulse = rise_q;
      fall_pulse = fall_q;
   end

`ifdef QUAD_GLITCH_COUNT_EN
   logic [7:0]  glitch_q;
   logic [15:0] abort_sum;
   logic [15:0] glitch_sum;

   always_comb begin
      abort_sum = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (chan_state[i] == ST_PENDING && sync[i] == clean_q[i]) abort_sum = abort_sum + 16'd1;
      end
      glitch_sum = {8'd0, glitch_q} + abort_sum;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) glitch_q <= '0;
      else          glitch_q <= (glitch_sum > 16'd255) ? 8'hFF : glitch_sum[7:0];
   end

   assign glitch_cnt = glitch_q;
`else
   assign glitch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_quad_input_filter.sv
// Self-checking bench for quad_input_filter (CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
`timescale 1ns/1ps
module tb_quad_input_filter;
   localparam int CH = 2;
   localparam int SS = 2;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [CH-1:0] raw_in = '0;
   logic [CH-1:0] clean_out;
   logic [CH-1:0] rise_pulse;
   logic [CH-1:0] fall_pulse;
   logic [7:0]    glitch_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: raw samples delayed SS edges, then a flip once the last DC
   // synchronised samples all disagree with the clean level.
   logic [CH-1:0] m_pipe [$];
   logic [CH-1:0] m_win [$];
   logic [CH-1:0] m_clean;
   logic [CH-1:0] m_rise;
   logic [CH-1:0] m_fall;
   logic [CH-1:0] m_prev;
   int            m_glitch;

   quad_input_filter #(
      .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .clean_out(clean_out),
      .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .glitch_cnt(glitch_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_pipe.delete();
      m_win.delete();
      for (int i = 0; i < SS; i++) m_pipe.push_back('0);
      for (int i = 0; i < DC; i++) m_win.push_back('0);
      m_clean  = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_prev   = '0;
      m_glitch = 0;
   endtask

   task automatic model_edge(input logic [CH-1:0] v);
      logic [CH-1:0] s;
      logic [CH-1:0] old;
      int            aborts;
      bit            all_diff;
      s = m_pipe.pop_front();
      m_pipe.push_back(v);
      m_win.push_back(s);
      if (m_win.size() > DC) old = m_win.pop_front();
      m_rise = '0;
      m_fall = '0;
      aborts = 0;
      for (int ch = 0; ch < CH; ch++) begin
         if (s[ch] == m_clean[ch] && m_prev[ch] != m_clean[ch]) aborts++;
         all_diff = 1'b1;
         for (int j = 0; j < m_win.size(); j++) begin
            if (m_win[j][ch] == m_clean[ch]) all_diff = 1'b0;
         end
         if (all_diff) begin
            m_clean[ch] = s[ch];
            if (s[ch]) m_rise[ch] = 1'b1;
            else       m_fall[ch] = 1'b1;
         end
      end
      m_prev = s;
`ifdef QUAD_GLITCH_COUNT_EN
      m_glitch = (m_glitch + aborts > 255) ? 255 : m_glitch + aborts;
`endif
   endtask

   task automatic step(input logic [CH-1:0] v);
      raw_in = v;
      @(posedge clk);
      model_edge(v);
      #1;
   endtask

   task automatic test_reset();
      logic [CH-1:0] exp_clean;
      logic [CH-1:0] exp_rise;
      reset_n = 1'b0;
      raw_in  = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (clean_out !== 2'b00) begin n_fail++; $display("FAIL reset_clean: got %b expected 00", clean_out); end
      n_checks++;
      if ({rise_pulse, fall_pulse} !== 4'b0000) begin n_fail++; $display("FAIL reset_pulses: got %b/%b expected 00/00", rise_pulse, fall_pulse); end
      n_checks++;
      if (glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_glitch: got %0d expected 0", glitch_cnt); end
      reset_n = 1'b1;
      model_reset();
      // Input held high through reset must produce a rise after the full latency.
      for (int d = 0; d < 8; d++) begin
         step(2'b11);
         exp_clean = (d >= 5) ? 2'b11 : 2'b00;
         exp_rise  = (d == 5) ? 2'b11 : 2'b00;
         n_checks++;
         if (clean_out !== exp_clean) begin n_fail++; $display("FAIL held_reset_clean d=%0d: got %b expected %b", d, clean_out, exp_clean); end
         n_checks++;
         if (rise_pulse !== exp_rise) begin n_fail++; $display("FAIL held_reset_rise d=%0d: got %b expected %b", d, rise_pulse, exp_rise); end
      end
      // Asynchronous assertion mid-cycle, no clock edge in between.
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (clean_out !== 2'b00) begin n_fail++; $display("FAIL async_reset_clean: got %b expected 00", clean_out); end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_clean_step();
      logic [CH-1:0] exp_rise;
      for (int i = 0; i < 4; i++) step(2'b00);
      for (int d = 0; d < 9; d++) begin
         step(2'b01);
         exp_rise = (d == 5) ? 2'b01 : 2'b00;
         n_checks++;
         if (clean_out[0] !== (d >= 5)) begin n_fail++; $display("FAIL step_clean0 d=%0d: got %b expected %b", d, clean_out[0], (d >= 5)); end
         n_checks++;
         if (rise_pulse !== exp_rise) begin n_fail++; $display("FAIL step_rise d=%0d: got %b expected %b", d, rise_pulse, exp_rise); end
         n_checks++;
         if (fall_pulse !== 2'b00) begin n_fail++; $display("FAIL step_fall d=%0d: got %b expected 00", d, fall_pulse); end
      end
      for (int d = 0; d < 8; d++) begin
         step(2'b00);
         n_checks++;
         if (fall_pulse !== m_fall || clean_out !== m_clean) begin
            n_fail++; $display("FAIL step_back d=%0d: got clean %b fall %b expected clean %b fall %b", d, clean_out, fall_pulse, m_clean, m_fall);
         end
      end
   endtask

   task automatic test_glitch();
      int exp_g;
`ifdef QUAD_GLITCH_COUNT_EN
      exp_g = m_glitch + 1;
`else
      exp_g = 0;
`endif
      step(2'b10);
      step(2'b10);
      for (int d = 0; d < 8; d++) begin
         step(2'b00);
         n_checks++;
         if (clean_out[1] !== 1'b0 || rise_pulse[1] !== 1'b0 || fall_pulse[1] !== 1'b0) begin
            n_fail++; $display("FAIL glitch_ch1 d=%0d: got clean %b rise %b fall %b expected 0/0/0", d, clean_out[1], rise_pulse[1], fall_pulse[1]);
         end
         n_checks++;
         if (glitch_cnt !== 8'(m_glitch)) begin n_fail++; $display("FAIL glitch_model d=%0d: got %0d expected %0d", d, glitch_cnt, m_glitch); end
      end
      n_checks++;
      if (glitch_cnt !== 8'(exp_g)) begin n_fail++; $display("FAIL glitch_count: got %0d expected %0d", glitch_cnt, exp_g); end
   endtask

   task automatic test_simultaneous();
      logic [CH-1:0] exp_clean;
      logic [CH-1:0] exp_fall;
      for (int i = 0; i < 8; i++) step(2'b11);
      n_checks++;
      if (clean_out !== 2'b11) begin n_fail++; $display("FAIL simul_setup: got %b expected 11", clean_out); end
      for (int d = 0; d < 8; d++) begin
         step(2'b00);
         exp_clean = (d >= 5) ? 2'b00 : 2'b11;
         exp_fall  = (d == 5) ? 2'b11 : 2'b00;
         n_checks++;
         if (clean_out !== exp_clean) begin n_fail++; $display("FAIL simul_clean d=%0d: got %b expected %b", d, clean_out, exp_clean); end
         n_checks++;
         if (fall_pulse !== exp_fall || rise_pulse !== 2'b00) begin
            n_fail++; $display("FAIL simul_pulses d=%0d: got fall %b rise %b expected fall %b rise 00", d, fall_pulse, rise_pulse, exp_fall);
         end
      end
   endtask

   task automatic test_reset_mid_pending();
      for (int d = 0; d < 3; d++) step(2'b01);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (clean_out !== 2'b00) begin n_fail++; $display("FAIL midpend_in_reset: got %b expected 00", clean_out); end
      reset_n = 1'b1;
      model_reset();
      for (int d = 0; d < 8; d++) begin
         step(2'b01);
         n_checks++;
         if (clean_out[0] !== (d >= 5)) begin n_fail++; $display("FAIL midpend_clean0 d=%0d: got %b expected %b", d, clean_out[0], (d >= 5)); end
         n_checks++;
         if (rise_pulse[0] !== (d == 5)) begin n_fail++; $display("FAIL midpend_rise0 d=%0d: got %b expected %b", d, rise_pulse[0], (d == 5)); end
      end
      for (int d = 0; d < 8; d++) step(2'b00);
   endtask

   task automatic test_random();
      logic [CH-1:0] cur;
      int            hold [CH];
      cur = '0;
      for (int ch = 0; ch < CH; ch++) hold[ch] = $urandom_range(1, 8);
      for (int c = 0; c < 400; c++) begin
         for (int ch = 0; ch < CH; ch++) begin
            hold[ch]--;
            if (hold[ch] == 0) begin
               cur[ch]  = ~cur[ch];
               hold[ch] = $urandom_range(1, 8);
            end
         end
         step(cur);
         n_checks++;
         if (clean_out !== m_clean) begin n_fail++; $display("FAIL rand_clean c=%0d: got %b expected %b", c, clean_out, m_clean); end
         n_checks++;
         if (rise_pulse !== m_rise || fall_pulse !== m_fall) begin
            n_fail++; $display("FAIL rand_pulses c=%0d: got rise %b fall %b expected rise %b fall %b", c, rise_pulse, fall_pulse, m_rise, m_fall);
         end
         n_checks++;
         if ((rise_pulse & fall_pulse) !== 2'b00) begin n_fail++; $display("FAIL rand_both_pulses c=%0d: got %b expected 00", c, rise_pulse & fall_pulse); end
         n_checks++;
         if (glitch_cnt !== 8'(m_glitch)) begin n_fail++; $display("FAIL rand_glitch c=%0d: got %0d expected %0d", c, glitch_cnt, m_glitch); end
      end
   endtask

   task automatic test_saturation();
      int exp_g;
`ifdef QUAD_GLITCH_COUNT_EN
      exp_g = 255;
`else
      exp_g = 0;
`endif
      for (int i = 0; i < 8; i++) step(2'b00);
      for (int g = 0; g < 300; g++) begin
         step(2'b01);
         for (int i = 0; i < 4; i++) step(2'b00);
      end
      n_checks++;
      if (glitch_cnt !== 8'(exp_g)) begin n_fail++; $display("FAIL sat_count: got %0d expected %0d", glitch_cnt, exp_g); end
      n_checks++;
      if (glitch_cnt !== 8'(m_glitch)) begin n_fail++; $display("FAIL sat_model: got %0d expected %0d", glitch_cnt, m_glitch); end
      n_checks++;
      if (clean_out !== 2'b00) begin n_fail++; $display("FAIL sat_clean: got %b expected 00", clean_out); end
      for (int g = 0; g < 20; g++) begin
         step(2'b01);
         for (int i = 0; i < 4; i++) step(2'b00);
      end
      n_checks++;
      if (glitch_cnt !== 8'(exp_g)) begin n_fail++; $display("FAIL sat_hold: got %0d expected %0d", glitch_cnt, exp_g); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_step();
      test_glitch();
      test_simultaneous();
      test_reset_mid_pending();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
